emu_mem_mp: RTL and testbench
=============================

// Module: emu_mem_mp
// PURPOSE
//  Parametrised multi-read-port emulated memory: one write port with byte strobes, NRPORT read ports.
//  Address window is [OFFSET, OFFSET+DEPTH); out-of-range accesses are flagged.
//  Reads are per-instance sync or async, with selectable read-during-write semantics.
//  Hardware zero-clear sweep after reset. Drop-in successor to the single-port mem in emulated designs.
// PARAMETERS
//  WIDTH     80   data bits per entry
//  DEPTH     32   entries (>=2)
//  AWIDTH    6    address bits; requires OFFSET+DEPTH <= 2**AWIDTH
//  OFFSET    0    first valid address; index = addr - OFFSET
//  NRPORT    2    read ports (>=1)
//  SYNCREAD  1    1: registered read (1-cycle latency); 0: combinational read
//  RDW_MODE  0    sync read of the entry being written this cycle: 0 = old data, 1 = new (strobe-merged)
//  CLEAR     1    1: sweep all entries to 0 after reset; 0: no sweep (contents undefined)
// PORTS
//  clk    in   1               clock
//  rst    in   1               synchronous, active-high reset
//  ren    in   NRPORT          read enable per port (ignored when SYNCREAD=0)
//  raddr  in   NRPORT*AWIDTH   read addresses, port p at [p*AWIDTH +: AWIDTH]
//  rdata  out  NRPORT*WIDTH    read data, port p at [p*WIDTH +: WIDTH]
//  rerr   out  NRPORT          read address out of window (timing aligned with rdata)
//  wen    in   1               write enable
//  waddr  in   AWIDTH          write address
//  wdata  in   WIDTH           write data
//  wstrb  in   ceil(WIDTH/8)   byte strobes; top lane covers WIDTH%8 bits when non-zero
//  werr   out  1               registered; 1 cycle after a dropped write (out of window or busy)
//  busy   out  1               clear sweep in progress
// BEHAVIOUR
//  - In-window: OFFSET <= addr <= OFFSET+DEPTH-1; compare at AWIDTH+1 bits, no wrap.
//  - Write: at posedge when wen && in-window && !busy, lanes with wstrb=1 updated; wstrb=0 -> no change, no werr.
//  - Dropped write (out of window, or busy): memory unchanged, werr=1 next cycle, else werr=0.
//  - SYNCREAD=1: at posedge with ren[p], rdata[p]/rerr[p] <= entry/oor-flag; ren[p]=0 holds both.
//    out of window or busy -> rdata 0, rerr per window check.
//    RDW same index: RDW_MODE=0 old entry; RDW_MODE=1 per-lane wdata where wstrb else old.
//  - SYNCREAD=0: rdata[p] = entry (0 if out of window or busy), rerr[p] combinational; write visible after edge.
//  - Ports independent; any ports may read the same index in one cycle.
//  - Clear FSM (CLEAR=1): IDLE / SWEEP.
//    rst -> SWEEP, ptr=0, busy=1.
//    SWEEP: each non-reset cycle writes 0 to entry ptr, ptr++; at ptr==DEPTH-1 write then -> IDLE, busy=0.
//    Sweep thus takes DEPTH cycles after rst falls. rst mid-sweep restarts at ptr=0.
//    CLEAR=0: FSM stays IDLE, busy=0.
//  - Reset values: rdata 0, rerr 0, werr 0, busy 1 (CLEAR=1) / 0 (CLEAR=0); sync read regs cleared.
//  - Write data path width WIDTH exactly; no padding bits are stored.
// STRUCTURE
//  - emu_mem_pkg: RDW_OLD/RDW_NEW constants, function in_window(addr, off, depth), strobe-to-bitmask function.
//  - Sub-module emu_mem_rport: window check, index subtract, optional output register, RDW merge;
//    generated NRPORT times. Storage array, write logic and clear FSM stay in top.
// TESTING  (WIDTH=80 DEPTH=32 OFFSET=32 AWIDTH=6 NRPORT=2 unless noted)
//  1. rst 1 cycle, count busy -> busy high exactly 32 cycles; every read of 32..63 then returns 0.
//  2. write addr 40 data 0x0123_4567_89AB_CDEF_0011, wstrb all 1; sync read p0 addr 40 -> data next cycle, rerr=0.
//  3. write addr 10 (below window) and addr 64-wrap attempt 6'd0 -> werr=1 next cycle, no entry changed;
//     read addr 5 -> rdata 0, rerr=1.
//  4. entry 33 = all-ones; write addr 33 wstrb=10'h001 data 0, with same-cycle read on both ports:
//     RDW_MODE=0 -> all-ones; RDW_MODE=1 -> low byte 0x00, rest ones.
//  5. assert rst at sweep cycle 10 after writing entry 50 -> sweep restarts, busy 32 more cycles; entry 50 reads 0.
//  6. SYNCREAD=0: read addr 45 while writing it -> old value same cycle, new value after edge; ren ignored.

Source files
------------

// File: rtl/emu_mem_pkg.sv
// Shared constants and helpers for the multi-read-port emulated memory.
package emu_mem_pkg;

  localparam int unsigned RDW_OLD   = 0;
  localparam int unsigned RDW_NEW   = 1;
  localparam int unsigned MAX_WIDTH = 512;
  localparam int unsigned MAX_STRB  = MAX_WIDTH / 8;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  // Widened compare so OFFSET+DEPTH never wraps at the address width.
  function automatic logic in_window(input logic [31:0] addr,
                                     input int unsigned off,
                                     input int unsigned depth);
    logic [33:0] a;
    logic [33:0] lo;
    logic [33:0] hi;
    a  = 34'(addr);
    lo = 34'(off);
    hi = 34'(off) + 34'(depth);
    return (a >= lo) && (a < hi);
  endfunction

  // Expands each strobe bit to an 8-bit lane; callers truncate to their width.
  function automatic logic [MAX_WIDTH-1:0] strb_to_mask(input logic [MAX_STRB-1:0] strb);
    logic [MAX_WIDTH-1:0] m;
    logic [MAX_STRB-1:0]  s;
    m = '0;
    s = strb;
    for (int unsigned i = 0; i < MAX_STRB; i++) begin
      m = {m[MAX_WIDTH-9:0], {8{s[MAX_STRB-1]}}};
      s = s << 1;
    end
    return m;
  endfunction

endpackage

// File: rtl/emu_mem_mp_rport.sv
// One read port: window check, index, optional output register and read-during-write merge.
module emu_mem_rport
  import emu_mem_pkg::*;
#(
  parameter int unsigned WIDTH    = 80,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AWIDTH   = 6,
  parameter int unsigned OFFSET   = 0,
  parameter int unsigned SYNCREAD = 1,
  parameter int unsigned RDW_MODE = 0,
  localparam int unsigned IWIDTH  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ren_i,
  input  logic [AWIDTH-1:0] raddr_i,
  input  logic              busy_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
  input  logic              wr_en_i,
  input  logic [IWIDTH-1:0] wr_idx_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [WIDTH-1:0]  wmask_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              rerr_o
);

  logic              in_win_c;
  logic [IWIDTH-1:0] idx_c;
  logic [WIDTH-1:0]  entry_c;
  logic              rdw_hit_c;
  logic [WIDTH-1:0]  merged_c;

  assign in_win_c  = in_window(32'(raddr_i), OFFSET, DEPTH);
  assign idx_c     = IWIDTH'(raddr_i - AWIDTH'(OFFSET));
  assign entry_c   = (in_win_c && !busy_i) ? mem_i[idx_c] : '0;
  // wr_en_i already excludes busy and out-of-window writes
  assign rdw_hit_c = (RDW_MODE == RDW_NEW) && wr_en_i && in_win_c && (idx_c == wr_idx_i);
  assign merged_c  = rdw_hit_c ? ((entry_c & ~wmask_i) | (wdata_i & wmask_i)) : entry_c;

  if (SYNCREAD != 0) begin : g_sync
    logic [WIDTH-1:0] rdata_q;
    logic             rerr_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdata_q <= '0;
        rerr_q  <= 1'b0;
      end else if (ren_i) begin
        rdata_q <= merged_c;
        rerr_q  <= !in_win_c;
      end
    end

    assign rdata_o = rdata_q;
    assign rerr_o  = rerr_q;
  end else begin : g_async
    assign rdata_o = entry_c;
    assign rerr_o  = !in_win_c;
  end

  logic unused_c;
  assign unused_c = ^{clk_i, rst_i, ren_i, merged_c, wdata_i, wmask_i, wr_idx_i, wr_en_i};

endmodule

// File: rtl/emu_mem_mp.sv
// Multi-read-port emulated memory: byte-strobed write port, NRPORT read ports, post-reset clear sweep.
module emu_mem_mp
  import emu_mem_pkg::*;
#(
  parameter int unsigned WIDTH    = 80,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AWIDTH   = 6,
  parameter int unsigned OFFSET   = 0,
  parameter int unsigned NRPORT   = 2,
  parameter int unsigned SYNCREAD = 1,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned CLEAR    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRPORT-1:0]        ren,
  input  logic [NRPORT*AWIDTH-1:0] raddr,
  output logic [NRPORT*WIDTH-1:0]  rdata,
  output logic [NRPORT-1:0]        rerr,
  input  logic                     wen,
  input  logic [AWIDTH-1:0]        waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [(WIDTH+7)/8-1:0]   wstrb,
  output logic                     werr,
  output logic                     busy
);

  localparam int unsigned IWIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  clr_state_e        state_q;
  logic [IWIDTH-1:0] ptr_q;
  logic              busy_q;
  logic              werr_q;

  logic              w_in_win_c;
  logic [IWIDTH-1:0] w_idx_c;
  logic              wr_en_c;
  logic              sweep_we_c;
  logic [WIDTH-1:0]  wmask_c;

  assign w_in_win_c = in_window(32'(waddr), OFFSET, DEPTH);
  assign w_idx_c    = IWIDTH'(waddr - AWIDTH'(OFFSET));
  assign wr_en_c    = wen && w_in_win_c && !busy_q;
  assign sweep_we_c = (state_q == CLR_SWEEP) && !rst;
  assign wmask_c    = WIDTH'(strb_to_mask(MAX_STRB'(wstrb)));

  // Clear sweep: one entry per cycle, busy drops together with the last entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR != 0) ? CLR_SWEEP : CLR_IDLE;
      ptr_q   <= '0;
      busy_q  <= (CLEAR != 0);
    end else if (state_q == CLR_SWEEP) begin
      if (ptr_q == IWIDTH'(DEPTH - 1)) begin
        state_q <= CLR_IDLE;
        ptr_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        ptr_q <= ptr_q + IWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_we_c) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en_c) begin
      mem_q[w_idx_c] <= (mem_q[w_idx_c] & ~wmask_c) | (wdata & wmask_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      werr_q <= 1'b0;
    end else begin
      werr_q <= wen && (!w_in_win_c || busy_q);
    end
  end

  assign werr = werr_q;
  assign busy = busy_q;

  for (genvar p = 0; p < NRPORT; p++) begin : g_rport
    emu_mem_rport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AWIDTH  (AWIDTH),
      .OFFSET  (OFFSET),
      .SYNCREAD(SYNCREAD),
      .RDW_MODE(RDW_MODE)
    ) u_rport (
      .clk_i   (clk),
      .rst_i   (rst),
      .ren_i   (ren[p]),
      .raddr_i (raddr[p*AWIDTH +: AWIDTH]),
      .busy_i  (busy_q),
      .mem_i   (mem_q),
      .wr_en_i (wr_en_c),
      .wr_idx_i(w_idx_c),
      .wdata_i (wdata),
      .wmask_i (wmask_c),
      .rdata_o (rdata[p*WIDTH +: WIDTH]),
      .rerr_o  (rerr[p])
    );
  end

endmodule

// File: tb/tb_emu_mem_mp.sv
// Bench for emu_mem_mp: sync/old, sync/new and async instances share one stimulus and one memory model.
module tb_emu_mem_mp;

  localparam int W   = 80;
  localparam int D   = 32;
  localparam int AW  = 6;
  localparam int OFF = 32;
  localparam int NP  = 2;
  localparam int NS  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   ren;
  logic [NP*AW-1:0] raddr;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [W-1:0]    wdata;
  logic [NS-1:0]   wstrb;

  logic [NP*W-1:0] rd_old, rd_new, rd_async;
  logic [NP-1:0]   re_old, re_new, re_async;
  logic            werr_old, werr_new, werr_async;
  logic            busy_old, busy_new, busy_async;

  // Reference model state
  logic [W-1:0] m_mem [D];
  int           sweep_left;
  logic [W-1:0] e_old [NP];
  logic [W-1:0] e_new [NP];
  logic         e_rerr [NP];
  logic         e_werr;
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  emu_mem_mp #(.WIDTH(W), .DEPTH(D), .AWIDTH(AW), .OFFSET(OFF), .NRPORT(NP),
               .SYNCREAD(1), .RDW_MODE(0), .CLEAR(1)) u_old (
    .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rd_old), .rerr(re_old),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .werr(werr_old), .busy(busy_old));

  emu_mem_mp #(.WIDTH(W), .DEPTH(D), .AWIDTH(AW), .OFFSET(OFF), .NRPORT(NP),
               .SYNCREAD(1), .RDW_MODE(1), .CLEAR(1)) u_new (
    .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rd_new), .rerr(re_new),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .werr(werr_new), .busy(busy_new));

  emu_mem_mp #(.WIDTH(W), .DEPTH(D), .AWIDTH(AW), .OFFSET(OFF), .NRPORT(NP),
               .SYNCREAD(0), .RDW_MODE(0), .CLEAR(1)) u_async (
    .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rd_async), .rerr(re_async),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .werr(werr_async), .busy(busy_async));

  function automatic logic win(input logic [AW-1:0] a);
    return (int'(a) >= OFF) && (int'(a) < OFF + D);
  endfunction

  function automatic logic [W-1:0] lanes(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [NS-1:0] s);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < W; b++) if (s[b/8]) r[b] = nw[b];
    return r;
  endfunction

  function automatic logic [W-1:0] async_exp(input logic [AW-1:0] a);
    return (win(a) && sweep_left == 0) ? m_mem[int'(a) - OFF] : '0;
  endfunction

  function automatic logic [W-1:0] rnd_data();
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Advance the model by one clock using the inputs currently driven, then step past the edge.
  task automatic tick();
    logic         busy_now;
    logic [AW-1:0] a;
    logic [W-1:0] cur;
    busy_now = (sweep_left > 0);
    for (int p = 0; p < NP; p++) begin
      a = raddr[p*AW +: AW];
      if (rst) begin
        e_old[p] = '0; e_new[p] = '0; e_rerr[p] = 1'b0;
      end else if (ren[p]) begin
        cur       = (win(a) && !busy_now) ? m_mem[int'(a) - OFF] : '0;
        e_old[p]  = cur;
        e_rerr[p] = !win(a);
        e_new[p]  = (win(a) && !busy_now && wen && win(waddr) && a == waddr)
                    ? lanes(cur, wdata, wstrb) : cur;
      end
    end
    e_werr = !rst && wen && (!win(waddr) || busy_now);
    if (wen && win(waddr) && !busy_now)
      m_mem[int'(waddr) - OFF] = lanes(m_mem[int'(waddr) - OFF], wdata, wstrb);
    if (rst) begin
      sweep_left = D;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; wen = 1'b0; ren = '0; waddr = '0; wdata = '0; wstrb = '0;
    raddr = {6'd32, 6'd32};
  endtask

  task automatic test_reset();
    int n;
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy_old, busy_new, busy_async} !== 3'b111) begin
      failures++; $display("FAIL reset_busy got %b exp 111", {busy_old, busy_new, busy_async}); end
    checks++; if ({rd_old, rd_new, re_old, re_new} !== '0) begin
      failures++; $display("FAIL reset_rd got %h %h %b %b exp 0", rd_old, rd_new, re_old, re_new); end
    checks++; if ({werr_old, werr_new, werr_async} !== 3'b000) begin
      failures++; $display("FAIL reset_werr got %b exp 000", {werr_old, werr_new, werr_async}); end
    checks++; if (rd_async !== '0 || re_async !== '0) begin
      failures++; $display("FAIL reset_async got %h %b exp 0", rd_async, re_async); end
    n = 0;
    while (busy_old === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != D) begin
      failures++; $display("FAIL busy_cycles got %0d exp %0d", n, D); end
    for (int a = OFF; a < OFF + D; a += 2) begin
      ren = 2'b11;
      raddr = {6'(a + 1), 6'(a)};
      @(negedge clk);
      checks++; if (rd_async !== '0 || re_async !== 2'b00) begin
        failures++; $display("FAIL clear_async a=%0d got %h %b exp 0", a, rd_async, re_async); end
      tick();
      checks++; if (rd_old !== '0 || rd_new !== '0 || re_old !== 2'b00 || re_new !== 2'b00) begin
        failures++; $display("FAIL clear_sync a=%0d got %h %h exp 0", a, rd_old, rd_new); end
    end
    drive_idle();
  endtask

  task automatic test_write_read();
    logic [W-1:0] k;
    k = 80'h0123_4567_89AB_CDEF_0011;
    wen = 1'b1; waddr = 6'd40; wdata = k; wstrb = '1;
    tick();
    wen = 1'b0; ren = 2'b01; raddr = {6'd32, 6'd40};
    checks++; if (werr_old !== 1'b0) begin
      failures++; $display("FAIL wr40_werr got %b exp 0", werr_old); end
    @(negedge clk);
    checks++; if (rd_async[W-1:0] !== k) begin
      failures++; $display("FAIL wr40_async got %h exp %h", rd_async[W-1:0], k); end
    tick();
    checks++; if (rd_old[W-1:0] !== k || rd_new[W-1:0] !== k || re_old[0] !== 1'b0) begin
      failures++; $display("FAIL wr40_sync got %h %h rerr %b exp %h", rd_old[W-1:0], rd_new[W-1:0], re_old[0], k); end
    drive_idle();
  endtask

  task automatic test_out_of_window();
    wen = 1'b1; waddr = 6'd10; wdata = rnd_data(); wstrb = '1;
    tick();
    checks++; if ({werr_old, werr_new, werr_async} !== 3'b111) begin
      failures++; $display("FAIL werr_low got %b exp 111", {werr_old, werr_new, werr_async}); end
    waddr = 6'd0;
    tick();
    checks++; if (werr_old !== 1'b1) begin
      failures++; $display("FAIL werr_wrap got %b exp 1", werr_old); end
    wen = 1'b0; ren = 2'b11; raddr = {6'd40, 6'd5};
    tick();
    checks++; if (werr_old !== 1'b0) begin
      failures++; $display("FAIL werr_clear got %b exp 0", werr_old); end
    checks++; if (rd_old[W-1:0] !== '0 || re_old[0] !== 1'b1 || re_new[0] !== 1'b1) begin
      failures++; $display("FAIL oor_read got %h rerr %b exp 0 rerr 1", rd_old[W-1:0], re_old[0]); end
    checks++; if (rd_old[2*W-1:W] !== m_mem[8] || re_old[1] !== 1'b0) begin
      failures++; $display("FAIL oor_untouched got %h exp %h", rd_old[2*W-1:W], m_mem[8]); end
    drive_idle();
  endtask

  task automatic test_rdw();
    logic [W-1:0] ones;
    logic [W-1:0] merged;
    ones = '1;
    merged = {{72{1'b1}}, 8'h00};
    wen = 1'b1; waddr = 6'd33; wdata = ones; wstrb = '1;
    tick();
    wdata = '0; wstrb = 10'h001; ren = 2'b11; raddr = {6'd33, 6'd33};
    @(negedge clk);
    checks++; if (rd_async !== {ones, ones}) begin
      failures++; $display("FAIL rdw_async_pre got %h exp all ones", rd_async); end
    tick();
    checks++; if (rd_old !== {ones, ones}) begin
      failures++; $display("FAIL rdw_old got %h exp %h", rd_old, {ones, ones}); end
    checks++; if (rd_new !== {merged, merged}) begin
      failures++; $display("FAIL rdw_new got %h exp %h", rd_new, {merged, merged}); end
    wen = 1'b0;
    tick();
    checks++; if (rd_old !== {merged, merged} || rd_async !== {merged, merged}) begin
      failures++; $display("FAIL rdw_after got %h %h exp %h", rd_old, rd_async, merged); end
    drive_idle();
  endtask

  task automatic test_async_rdw();
    logic [W-1:0] va, vb;
    va = rnd_data();
    vb = ~va;
    wen = 1'b1; waddr = 6'd45; wdata = va; wstrb = '1;
    tick();
    wdata = vb; ren = 2'b00; raddr = {6'd32, 6'd45};
    @(negedge clk);
    checks++; if (rd_async[W-1:0] !== va) begin
      failures++; $display("FAIL async_pre got %h exp %h", rd_async[W-1:0], va); end
    tick();
    checks++; if (rd_async[W-1:0] !== vb) begin
      failures++; $display("FAIL async_post got %h exp %h", rd_async[W-1:0], vb); end
    checks++; if (rd_old[W-1:0] !== e_old[0]) begin
      failures++; $display("FAIL sync_hold got %h exp %h", rd_old[W-1:0], e_old[0]); end
    drive_idle();
  endtask

  task automatic test_reset_midsweep();
    int n;
    wen = 1'b1; wstrb = '1;
    for (int i = 0; i < 3; i++) begin
      waddr = (i == 0) ? 6'd32 : (i == 1) ? 6'd50 : 6'd63;
      wdata = rnd_data();
      tick();
    end
    wen = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n = 0;
    while (busy_old === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != D) begin
      failures++; $display("FAIL midsweep_busy got %0d exp %0d", n, D); end
    ren = 2'b11; raddr = {6'd63, 6'd50};
    tick();
    checks++; if (rd_old !== '0 || rd_new !== '0) begin
      failures++; $display("FAIL midsweep_clear got %h %h exp 0", rd_old, rd_new); end
    raddr = {6'd32, 6'd32};
    tick();
    checks++; if (rd_old !== '0) begin
      failures++; $display("FAIL midsweep_first got %h exp 0", rd_old); end
    drive_idle();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 500; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      wen   = $urandom_range(0, 1) == 1;
      waddr = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'(OFF + $urandom_range(0, D - 1));
      wdata = rnd_data();
      wstrb = NS'($urandom());
      ren   = NP'($urandom());
      for (int p = 0; p < NP; p++)
        raddr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr
                           : ($urandom_range(0, 4) == 0) ? 6'($urandom())
                           : 6'(OFF + $urandom_range(0, D - 1));
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        a = raddr[p*AW +: AW];
        checks++; if (rd_async[p*W +: W] !== async_exp(a) || re_async[p] !== !win(a)) begin
          failures++; $display("FAIL rnd_async c=%0d p=%0d a=%0d got %h %b exp %h %b",
                               c, p, a, rd_async[p*W +: W], re_async[p], async_exp(a), !win(a)); end
      end
      tick();
      for (int p = 0; p < NP; p++) begin
        checks++; if (rd_old[p*W +: W] !== e_old[p] || re_old[p] !== e_rerr[p]) begin
          failures++; $display("FAIL rnd_old c=%0d p=%0d got %h %b exp %h %b",
                               c, p, rd_old[p*W +: W], re_old[p], e_old[p], e_rerr[p]); end
        checks++; if (rd_new[p*W +: W] !== e_new[p] || re_new[p] !== e_rerr[p]) begin
          failures++; $display("FAIL rnd_new c=%0d p=%0d got %h %b exp %h %b",
                               c, p, rd_new[p*W +: W], re_new[p], e_new[p], e_rerr[p]); end
      end
      checks++; if ({werr_old, werr_new, werr_async} !== {3{e_werr}}
                    || {busy_old, busy_new, busy_async} !== {3{sweep_left > 0}}) begin
        failures++; $display("FAIL rnd_ctrl c=%0d werr %b busy %b exp werr %b busy %b",
                             c, {werr_old, werr_new, werr_async}, {busy_old, busy_new, busy_async},
                             e_werr, sweep_left > 0); end
    end
    drive_idle();
  endtask

  initial begin
    sweep_left = 0;
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    for (int p = 0; p < NP; p++) begin e_old[p] = '0; e_new[p] = '0; e_rerr[p] = 1'b0; end
    e_werr = 1'b0;
    test_reset();
    test_write_read();
    test_out_of_window();
    test_rdw();
    test_async_rdw();
    test_reset_midsweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout no completion");
    $fatal(1);
  end

endmodule
